// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the register-file write-back slice.
//   XLEN             integer data width
//   F3_*             load funct3 encodings
//   wb_entry_t       pending ALU write {rd, data} held in the skid buffer
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data formatter: extracts the addressed byte/halfword from an aligned
// memory word and sign- or zero-extends it according to funct3.
//   funct3  load type
//   offset  byte address bits [1:0]; bit 0 ignored for halfwords
//   word    raw aligned memory word
//   data    formatted register value ('0 when funct3 is not a load type)
//   valid   funct3 is one of LB/LH/LW/LBU/LHU
module wb_load_align
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = rv32i_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            valid
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    data     = '0;
    valid    = 1'b0;
    unique case (funct3)
      F3_LB:  begin data = {{(XLEN-8){byte_sel[7]}}, byte_sel};   valid = 1'b1; end
      F3_LH:  begin data = {{(XLEN-16){half_sel[15]}}, half_sel}; valid = 1'b1; end
      F3_LW:  begin data = word;                                  valid = 1'b1; end
      F3_LBU: begin data = {{(XLEN-8){1'b0}}, byte_sel};          valid = 1'b1; end
      F3_LHU: begin data = {{(XLEN-16){1'b0}}, half_sel};         valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side controller for the RV32I integer register file.
// Merges load responses (highest priority), buffered ALU results and direct
// ALU results into the single registered write port we3/address3/wd3, and
// tracks pending loads so decode can stall on rs1/rs2 hazards.
//   clk, rst            clock; asynchronous active-low reset
//   alu_*               ALU result valid/ready handshake with rd and data
//   ld_issue(_rd)       load issued to memory; marks rd busy
//   ld_*                load response (always accepted), formatted by funct3
//   rs1/rs2_addr,_busy  decode hazard query
//   fwd1/fwd2_*         write-port forwarding (REGFILE_WB_FORWARD_EN only)
//   we3/address3/wd3    registered register-file write port
// Macro REGFILE_WB_FORWARD_EN: forward the in-flight write instead of
// reporting it as busy.
module regfile_writeback
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN           = rv32i_pkg::XLEN,
  parameter int unsigned ALU_FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_word,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            fwd1_valid,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd2_data,
  output logic            we3,
  output logic [4:0]      address3,
  output logic [XLEN-1:0] wd3
);

  localparam int unsigned PW = $clog2(ALU_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t       fifo_q [ALU_FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     busy_q, busy_n;

  logic            full, empty, alu_acc, do_pop, do_byp, do_push;
  wb_entry_t       head;
  logic [XLEN-1:0] ld_fmt;
  logic            ld_fmt_valid;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            hit1, hit2, infl1, infl2;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .funct3 (ld_funct3),
    .offset (ld_offset),
    .word   (ld_word),
    .data   (ld_fmt),
    .valid  (ld_fmt_valid)
  );

  // Source selection: load > FIFO head > direct bypass (FIFO empty only,
  // which keeps ALU results in order). Accepted ALU results that are not
  // bypassed are pushed, including rd=0 ones, so their handshake completes.
  always_comb begin
    full      = (count == CW'(ALU_FIFO_DEPTH));
    empty     = (count == '0);
    alu_ready = !full;
    alu_acc   = alu_valid && !full;
    do_pop    = !ld_valid && !empty;
    do_byp    = !ld_valid && empty && alu_acc;
    do_push   = alu_acc && !do_byp;
    head      = fifo_q[rd_ptr];
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    if (ld_valid) begin
      wr_en   = ld_fmt_valid && (ld_rd != '0);
      wr_addr = ld_rd;
      wr_data = ld_fmt;
    end else if (do_pop) begin
      wr_en   = (head.rd != '0);
      wr_addr = head.rd;
      wr_data = head.data;
    end else if (do_byp) begin
      wr_en   = (alu_rd != '0);
      wr_addr = alu_rd;
      wr_data = alu_data;
    end
  end

  // Set after clear so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_n = busy_q;
    if (ld_valid) busy_n[ld_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != '0)) busy_n[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3      <= 1'b0;
      address3 <= '0;
      wd3      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      busy_q   <= '0;
      for (int unsigned i = 0; i < ALU_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      we3    <= wr_en;
      busy_q <= busy_n;
      if (wr_en) begin
        address3 <= wr_addr;
        wd3      <= wr_data;
      end
      if (do_push) begin
        fifo_q[wr_ptr] <= '{rd: alu_rd, data: alu_data};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Hazard terms: pending load, buffered ALU write, and the write on the port
  // now (the register file only sees it at the next edge).
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < ALU_FIFO_DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (fifo_q[rd_ptr + PW'(i)].rd == rs1_addr) hit1 = 1'b1;
        if (fifo_q[rd_ptr + PW'(i)].rd == rs2_addr) hit2 = 1'b1;
      end
    end
    infl1 = we3 && (address3 == rs1_addr);
    infl2 = we3 && (address3 == rs2_addr);
`ifdef REGFILE_WB_FORWARD_EN
    rs1_busy   = (rs1_addr != '0) && (busy_q[rs1_addr] || hit1);
    rs2_busy   = (rs2_addr != '0) && (busy_q[rs2_addr] || hit2);
    fwd1_valid = (rs1_addr != '0) && infl1;
    fwd2_valid = (rs2_addr != '0) && infl2;
    fwd1_data  = fwd1_valid ? wd3 : '0;
    fwd2_data  = fwd2_valid ? wd3 : '0;
`else
    rs1_busy   = (rs1_addr != '0) && (busy_q[rs1_addr] || hit1 || infl1);
    rs2_busy   = (rs2_addr != '0) && (busy_q[rs2_addr] || hit2 || infl2);
    fwd1_valid = 1'b0;
    fwd2_valid = 1'b0;
    fwd1_data  = '0;
    fwd2_data  = '0;
`endif
  end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int unsigned XLEN = 32;
`ifdef REGFILE_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_offset;
  logic [XLEN-1:0] ld_word;
  logic [4:0]      rs1_addr, rs2_addr;
  logic            rs1_busy, rs2_busy;
  logic            fwd1_valid, fwd2_valid;
  logic [XLEN-1:0] fwd1_data, fwd2_data;
  logic            we3;
  logic [4:0]      address3;
  logic [XLEN-1:0] wd3;

  regfile_writeback #(.XLEN(XLEN), .ALU_FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_offset(ld_offset), .ld_word(ld_word),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data), .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
    .we3(we3), .address3(address3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned av, ard, adat, li, lird, lv, lrd, f3, off, word, rs1, rs2;
    int unsigned rdy, b1s, b1w, b2s, b2w, we, a, wd;
  } vec_t;

  vec_t vq[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] last_wd = '0;

  function automatic void add(input int unsigned av, ard, adat, li, lird, lv, lrd, f3, off, word,
                              rs1, rs2, rdy, b1s, b1w, b2s, b2w, we, a, wd);
    vec_t v;
    v = '{av, ard, adat, li, lird, lv, lrd, f3, off, word, rs1, rs2, rdy, b1s, b1w, b2s, b2w, we, a, wd};
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_offset = '0; ld_word = '0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    logic e1, e2, f1, f2;
    alu_valid = v.av[0]; alu_rd = 5'(v.ard); alu_data = v.adat;
    ld_issue = v.li[0]; ld_issue_rd = 5'(v.lird);
    ld_valid = v.lv[0]; ld_rd = 5'(v.lrd); ld_funct3 = 3'(v.f3); ld_offset = 2'(v.off); ld_word = v.word;
    rs1_addr = 5'(v.rs1); rs2_addr = 5'(v.rs2);
    #1;
    e1 = (v.b1s != 0) || ((v.b1w != 0) && !FWD);
    e2 = (v.b2s != 0) || ((v.b2w != 0) && !FWD);
    f1 = (v.b1w != 0) && FWD;
    f2 = (v.b2w != 0) && FWD;
    chk($sformatf("v%0d alu_ready", idx), 32'(alu_ready), v.rdy);
    chk($sformatf("v%0d rs1_busy", idx), 32'(rs1_busy), 32'(e1));
    chk($sformatf("v%0d rs2_busy", idx), 32'(rs2_busy), 32'(e2));
    chk($sformatf("v%0d fwd1_valid", idx), 32'(fwd1_valid), 32'(f1));
    chk($sformatf("v%0d fwd1_data", idx), fwd1_data, f1 ? last_wd : 32'h0);
    chk($sformatf("v%0d fwd2_valid", idx), 32'(fwd2_valid), 32'(f2));
    chk($sformatf("v%0d fwd2_data", idx), fwd2_data, f2 ? last_wd : 32'h0);
    @(posedge clk); #1;
    chk($sformatf("v%0d we3", idx), 32'(we3), v.we);
    if (v.we != 0) begin
      chk($sformatf("v%0d address3", idx), 32'(address3), v.a);
      chk($sformatf("v%0d wd3", idx), wd3, v.wd);
      last_wd = v.wd;
    end
    vectors++;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    rs1_addr = '0; rs2_addr = '0;

    //  av ard adat        li lird lv lrd f3 off word          rs1 rs2 | rdy b1s b1w b2s b2w we a  wd
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             0,  0,    1,  0,  0,  0,  0,  0, 0, 0);
    add(1, 5,  'h1234,     0, 0,   0, 0,  0, 0, 0,             5,  0,    1,  0,  0,  0,  0,  1, 5, 'h1234);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             5,  0,    1,  0,  1,  0,  0,  0, 0, 0);
    add(1, 8,  'hA,        0, 0,   1, 7,  0, 3, 'h80FFFFFF,    8,  7,    1,  0,  0,  0,  0,  1, 7, 'hFFFFFF80);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             8,  7,    1,  1,  0,  0,  1,  1, 8, 'hA);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             8,  7,    1,  0,  1,  0,  0,  0, 0, 0);
    add(1, 11, 'h11,       0, 0,   1, 10, 2, 0, 'h11111111,    11, 10,   1,  0,  0,  0,  0,  1, 10, 'h11111111);
    add(1, 13, 'h13,       0, 0,   1, 12, 2, 0, 'h22222222,    11, 13,   1,  1,  0,  0,  0,  1, 12, 'h22222222);
    add(1, 15, 'h15,       0, 0,   1, 14, 2, 0, 'h33333333,    13, 12,   0,  1,  0,  0,  1,  1, 14, 'h33333333);
    add(1, 15, 'h15,       0, 0,   0, 0,  0, 0, 0,             15, 11,   0,  0,  0,  1,  0,  1, 11, 'h11);
    add(1, 15, 'h15,       0, 0,   0, 0,  0, 0, 0,             13, 11,   1,  1,  0,  0,  1,  1, 13, 'h13);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             15, 13,   1,  1,  0,  0,  1,  1, 15, 'h15);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             15, 0,    1,  0,  1,  0,  0,  0, 0, 0);
    add(0, 0,  0,          1, 9,   0, 0,  0, 0, 0,             9,  0,    1,  0,  0,  0,  0,  0, 0, 0);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             9,  0,    1,  1,  0,  0,  0,  0, 0, 0);
    add(0, 0,  0,          0, 0,   1, 9,  5, 2, 'hBEEF0001,    9,  0,    1,  1,  0,  0,  0,  1, 9, 'h0000BEEF);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             9,  0,    1,  0,  1,  0,  0,  0, 0, 0);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             9,  0,    1,  0,  0,  0,  0,  0, 0, 0);
    add(0, 0,  0,          1, 9,   0, 0,  0, 0, 0,             9,  0,    1,  0,  0,  0,  0,  0, 0, 0);
    add(0, 0,  0,          1, 9,   1, 9,  2, 0, 'h99,          9,  0,    1,  1,  0,  0,  0,  1, 9, 'h99);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             9,  0,    1,  1,  1,  0,  0,  0, 0, 0);
    add(0, 0,  0,          0, 0,   1, 9,  0, 0, 'h7F,          9,  0,    1,  1,  0,  0,  0,  1, 9, 'h7F);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             9,  0,    1,  0,  1,  0,  0,  0, 0, 0);
    add(0, 0,  0,          0, 0,   1, 16, 1, 2, 'h80011234,    0,  0,    1,  0,  0,  0,  0,  1, 16, 'hFFFF8001);
    add(0, 0,  0,          0, 0,   1, 17, 4, 1, 'h0000F000,    0,  0,    1,  0,  0,  0,  0,  1, 17, 'h000000F0);
    add(0, 0,  0,          0, 0,   1, 18, 1, 1, 'h12348000,    0,  0,    1,  0,  0,  0,  0,  1, 18, 'hFFFF8000);
    add(0, 0,  0,          0, 0,   1, 18, 5, 3, 'h87654321,    0,  0,    1,  0,  0,  0,  0,  1, 18, 'h00008765);
    add(0, 0,  0,          1, 19,  0, 0,  0, 0, 0,             19, 0,    1,  0,  0,  0,  0,  0, 0, 0);
    add(0, 0,  0,          0, 0,   1, 19, 3, 0, 'hDEAD,        19, 0,    1,  1,  0,  0,  0,  0, 0, 0);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             19, 0,    1,  0,  0,  0,  0,  0, 0, 0);
    add(1, 0,  'h55,       0, 0,   0, 0,  0, 0, 0,             0,  0,    1,  0,  0,  0,  0,  0, 0, 0);
    add(0, 0,  0,          1, 0,   1, 0,  2, 0, 'h1,           0,  0,    1,  0,  0,  0,  0,  0, 0, 0);
    add(1, 0,  'h77,       0, 0,   1, 20, 2, 0, 'h20,          0,  20,   1,  0,  0,  0,  0,  1, 20, 'h20);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             0,  20,   1,  0,  0,  0,  1,  0, 0, 0);
    add(0, 0,  0,          0, 0,   0, 0,  0, 0, 0,             0,  20,   1,  0,  0,  0,  0,  0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset we3", 32'(we3), 32'h0);
    chk("reset address3", 32'(address3), 32'h0);
    chk("reset wd3", wd3, 32'h0);
    chk("reset alu_ready", 32'(alu_ready), 32'h1);
    vectors++;
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) apply(i, vq[i]);

    // Fill the FIFO and set a busy bit, then reset mid-cycle.
    alu_valid = 1'b1; alu_rd = 5'd23; alu_data = 32'h23;
    ld_valid = 1'b1; ld_rd = 5'd21; ld_funct3 = 3'b010; ld_word = 32'hA1;
    ld_issue = 1'b1; ld_issue_rd = 5'd25;
    @(posedge clk); #1;
    alu_rd = 5'd24; alu_data = 32'h24;
    ld_rd = 5'd22; ld_word = 32'hA2; ld_issue = 1'b0;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    ld_rd = 5'd26; ld_word = 32'hA6;
    rs1_addr = 5'd25; rs2_addr = 5'd23;
    #1;
    chk("prerst we3", 32'(we3), 32'h1);
    chk("prerst alu_ready", 32'(alu_ready), 32'h0);
    chk("prerst rs1_busy", 32'(rs1_busy), 32'h1);
    chk("prerst rs2_busy", 32'(rs2_busy), 32'h1);
    vectors++;
    rst = 1'b0;
    #1;
    chk("async we3", 32'(we3), 32'h0);
    chk("async address3", 32'(address3), 32'h0);
    chk("async wd3", wd3, 32'h0);
    chk("async alu_ready", 32'(alu_ready), 32'h1);
    chk("async rs1_busy", 32'(rs1_busy), 32'h0);
    chk("async rs2_busy", 32'(rs2_busy), 32'h0);
    vectors++;
    @(posedge clk); #1;
    chk("inrst we3", 32'(we3), 32'h0);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("postrst alu_ready", 32'(alu_ready), 32'h1);
    chk("postrst rs1_busy", 32'(rs1_busy), 32'h0);
    chk("postrst rs2_busy", 32'(rs2_busy), 32'h0);
    @(posedge clk); #1;
    chk("postrst we3", 32'(we3), 32'h0);
    vectors++;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side controller for the RV32I integer register file.
- Merges ALU results and load-memory responses into the register file's single write port (we3/address3/wd3).
- Aligns and extends load data by byte, halfword or word.
- Keeps a pending-load scoreboard so the decode stage can stall on hazards against rs1/rs2.

Parameters:
- XLEN, 32, data width.
- ALU_FIFO_DEPTH, 2, ALU result skid-buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_issue  in  1  load issued to memory this cycle.
- ld_issue_rd  in  5  issued load's destination register.
- ld_valid  in  1  load response present (always accepted).
- ld_rd  in  5  load destination register.
- ld_funct3  in  3  load type.
- ld_offset  in  2  byte address bits [1:0].
- ld_word  in  XLEN  raw aligned memory word.
- rs1_addr  in  5  decode source register 1.
- rs2_addr  in  5  decode source register 2.
- rs1_busy  out  1  rs1 value not yet valid in the register file.
- rs2_busy  out  1  rs2 value not yet valid in the register file.
- fwd1_valid  out  1  forwarding hit on rs1 (optional feature).
- fwd1_data  out  XLEN  forwarded rs1 value (optional feature).
- fwd2_valid  out  1  forwarding hit on rs2 (optional feature).
- fwd2_data  out  XLEN  forwarded rs2 value (optional feature).
- we3  out  1  register file write enable, registered.
- address3  out  5  register file write address, registered.
- wd3  out  XLEN  register file write data, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - we3=0, address3=0, wd3=0.
  - FIFO emptied; all scoreboard bits cleared.
  - Any in-flight result is discarded, including mid-operation.
- One write per cycle; we3/address3/wd3 update on the clock edge after a source is selected (latency 1).
- Source priority per cycle:
  - ld_valid wins.
  - Else FIFO head (pop).
  - Else direct ALU bypass when FIFO empty and alu_valid.
- ALU handshake:
  - alu_ready = FIFO not full.
  - Accepted ALU results not written this cycle are pushed into the FIFO.
  - Push and pop in the same cycle are allowed; order is preserved.
  - Full FIFO with ld_valid: alu_ready=0, FIFO head stalls.
- Destination rd=0: handshake is consumed, we3 stays 0; scoreboard bit 0 is never set.
- Load formatting by ld_funct3:
  - 000 LB: byte at ld_offset, sign-extended.
  - 001 LH: half selected by ld_offset[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte at ld_offset, zero-extended.
  - 101 LHU: half selected by ld_offset[1], zero-extended.
  - Any other value: write suppressed, busy bit still cleared.
  - ld_offset[0] is ignored for halfwords; alignment is checked upstream.
- Scoreboard (32 bits):
  - ld_issue sets busy[ld_issue_rd] (rd≠0).
  - An accepted load response clears busy[ld_rd].
  - Issue and completion to the same rd in the same cycle: the set wins.
  - Issue to a register already busy keeps it busy; no counting.
- rsN_busy is asserted when any of the following holds:
  - busy[rsN];
  - any valid FIFO entry has rd==rsN;
  - we3 && address3==rsN, since the register file is not updated until that edge.
  - rsN=0 never reports busy.

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- Defined:
  - When we3 && address3==rsN≠0, fwdN_valid=1 and fwdN_data=wd3.
  - That in-flight term is removed from rsN_busy.
  - The load scoreboard and FIFO terms still assert busy.
- Undefined: fwdN_valid=0, fwdN_data=0; busy as specified above.

Decomposition:
- Package rv32i_pkg:
  - XLEN.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Typedef of the FIFO entry {rd[4:0], data[XLEN-1:0]}.
- Sub-module wb_load_align: purely combinational extract/extend from (funct3, offset, word), with a valid flag for a legal funct3.
- The FIFO stays inline.

Test Plan:
- ALU alu_valid, rd=5, data=0x1234 with no load:
  - Next cycle we3=1, address3=5, wd3=0x1234.
  - alu_ready stays 1 throughout.
- ld_valid LB, offset=3, word=0x80FF_FFFF, rd=7, same cycle as ALU rd=8, data=0xA:
  - Cycle+1: x7 written with 0xFFFF_FF80.
  - Cycle+2: x8 written with 0xA.
- Load backpressure:
  - Three back-to-back loads while ALU streams: alu_ready falls after 2 pushes.
  - After the loads stop, ALU writes drain in order.
- Scoreboard:
  - ld_issue rd=9; rs1_addr=9 → rs1_busy=1.
  - LHU response, offset=2, word=0xBEEF_0001 → x9=0x0000_BEEF.
  - rs1_busy falls the cycle after write.
  - Same-cycle issue and completion on rd=9 keeps busy=1.
- rd=0 ALU and load writes: we3 stays 0; rs1_addr=0 never busy.
- Reset asserted with FIFO full and busy bits set:
  - Outputs go to 0 immediately.
  - After release, alu_ready=1 and all busy=0.
